// File: rtl/das_arr_multi.sv
// das_arr_multi: per-channel button synchroniser with press pulse,
// delayed-auto-shift pulse and auto-repeat pulse train while held.
module das_arr_multi #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [NUM_CH-1:0] action_user,
    input  logic [NUM_CH-1:0] action_valid,
    input  logic [NUM_CH-1:0] repeat_en,
    input  logic [CNT_W-1:0]  das_cycles,
    input  logic [CNT_W-1:0]  arr_cycles,
    output logic [NUM_CH-1:0] action_out,
    output logic [NUM_CH-1:0] held
);

    typedef enum logic [1:0] {
        IDLE,
        DAS_WAIT,
        ARR_WAIT,
        HOLD
    } state_e;

    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [NUM_CH-1:0] pulse_q, pulse_d;
    logic [NUM_CH-1:0] held_q, held_d;
    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [CNT_W-1:0]  das_load, arr_load;

    // A zero period behaves like a period of one.
    assign das_load = (das_cycles == '0) ? '0 : das_cycles - CNT_W'(1);
    assign arr_load = (arr_cycles == '0) ? '0 : arr_cycles - CNT_W'(1);

    assign sync1_d = action_user;
    assign sync2_d = sync1_q;

    always_comb begin
        pulse_d = '0;
        held_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                IDLE: begin
                    cnt_d[i] = '0;
                    if (sync2_q[i] && action_valid[i]) begin
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = das_load;
                        state_d[i] = DAS_WAIT;
                    end
                end
                DAS_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else begin
                        pulse_d[i] = action_valid[i];
                        if (repeat_en[i]) begin
                            state_d[i] = ARR_WAIT;
                            cnt_d[i]   = arr_load;
                        end else begin
                            state_d[i] = HOLD;
                            cnt_d[i]   = '0;
                        end
                    end
                end
                ARR_WAIT: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end else if (repeat_en[i]) begin
                        pulse_d[i] = action_valid[i];
                        cnt_d[i]   = arr_load;
                    end else begin
                        // Repeat withdrawn mid-train: stop silently at expiry.
                        state_d[i] = HOLD;
                        cnt_d[i]   = '0;
                    end
                end
                HOLD: begin
                    cnt_d[i] = '0;
                    if (!sync2_q[i]) state_d[i] = IDLE;
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            held_d[i] = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync1_q <= '0;
            sync2_q <= '0;
            pulse_q <= '0;
            held_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign action_out = pulse_q;
    assign held       = held_q;

endmodule

// File: tb/tb_das_arr_multi.sv
// tb_das_arr_multi: directed scenarios for the DAS/ARR generator.
module tb_das_arr_multi;

    logic        clk;
    logic        rst_l;
    logic [3:0]  action_user;
    logic [3:0]  action_valid;
    logic [3:0]  repeat_en;
    logic [31:0] das_cycles;
    logic [31:0] arr_cycles;
    logic [3:0]  action_out;
    logic [3:0]  held;

    int errors = 0;
    int checks = 0;

    das_arr_multi #(.NUM_CH(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .action_user  (action_user),
        .action_valid (action_valid),
        .repeat_en    (repeat_en),
        .das_cycles   (das_cycles),
        .arr_cycles   (arr_cycles),
        .action_out   (action_out),
        .held         (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        action_user = '0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (action_out !== 4'b0 || held !== 4'b0) begin
            errors++;
            $display("FAIL reset out=%b held=%b expected 0000/0000",
                     action_out, held);
        end
        tick();
        rst_l = 1'b1;
        idle(3);
    endtask

    // Press ch0 for len sampled edges; pulses expected at cycles in ep.
    task automatic test_tap();
        logic [63:0] ep, eh;
        das_cycles = 10; arr_cycles = 4; repeat_en = 4'hF; action_valid = 4'hF;
        ep = '0; ep[3] = 1'b1;
        eh = '0;
        for (int c = 3; c <= 7; c++) eh[c] = 1'b1;
        action_user[0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            checks++;
            if (action_out !== {3'b0, ep[c]} || held !== {3'b0, eh[c]}) begin
                errors++;
                $display("FAIL tap c=%0d out=%b held=%b expected %b/%b",
                         c, action_out, held, ep[c], eh[c]);
            end
            if (c == 5) action_user[0] = 1'b0;
        end
        idle(4);
    endtask

    task automatic test_hold(input logic rep);
        logic [63:0] ep, eh;
        das_cycles = 10; arr_cycles = 4; repeat_en = {4{rep}};
        ep = '0; eh = '0;
        ep[3] = 1'b1; ep[13] = 1'b1;
        if (rep)
            for (int c = 17; c <= 42; c += 4) ep[c] = 1'b1;
        for (int c = 3; c <= 42; c++) eh[c] = 1'b1;
        action_user[0] = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            checks++;
            if (action_out[0] !== ep[c] || held[0] !== eh[c]) begin
                errors++;
                $display("FAIL hold rep=%b c=%0d out=%b held=%b expected %b/%b",
                         rep, c, action_out[0], held[0], ep[c], eh[c]);
            end
            if (c == 40) action_user[0] = 1'b0;
        end
        repeat_en = 4'hF;
        idle(4);
    endtask

    task automatic test_valid_gating();
        logic [63:0] ep, eh;
        das_cycles = 10; arr_cycles = 4;
        ep = '0; eh = '0;
        ep[3] = 1'b1; ep[13] = 1'b1; ep[21] = 1'b1; ep[25] = 1'b1;
        for (int c = 3; c <= 27; c++) eh[c] = 1'b1;
        action_user[0] = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            tick();
            checks++;
            if (action_out[0] !== ep[c] || held[0] !== eh[c]) begin
                errors++;
                $display("FAIL valid_drop c=%0d out=%b held=%b expected %b/%b",
                         c, action_out[0], held[0], ep[c], eh[c]);
            end
            if (c == 16) action_valid[0] = 1'b0;
            if (c == 17) action_valid[0] = 1'b1;
        end
        idle(4);
        // Press while consumer not ready: nothing until valid rises.
        ep = '0; eh = '0;
        ep[9] = 1'b1; ep[19] = 1'b1;
        for (int c = 9; c <= 22; c++) eh[c] = 1'b1;
        action_valid[0] = 1'b0;
        action_user[0] = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            checks++;
            if (action_out[0] !== ep[c] || held[0] !== eh[c]) begin
                errors++;
                $display("FAIL valid_press c=%0d out=%b held=%b expected %b/%b",
                         c, action_out[0], held[0], ep[c], eh[c]);
            end
            if (c == 8) action_valid[0] = 1'b1;
        end
        idle(4);
    endtask

    task automatic test_multi_channel();
        logic [3:0] eo, eh;
        das_cycles = 6; arr_cycles = 2;
        action_user[0] = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            eo = '0; eh = '0;
            eo[0] = (c == 3) || (c >= 9 && c % 2 == 1);
            eo[2] = (c == 6) || (c >= 12 && c % 2 == 0);
            eo[1] = (c == 7) || (c >= 13 && c % 2 == 1);
            eh[0] = (c >= 3);
            eh[2] = (c >= 6);
            eh[1] = (c >= 7);
            checks++;
            if (action_out !== eo || held !== eh) begin
                errors++;
                $display("FAIL multi c=%0d out=%b held=%b expected %b/%b",
                         c, action_out, held, eo, eh);
            end
            if (c == 3) action_user[2] = 1'b1;
            if (c == 4) action_user[1] = 1'b1;
        end
        idle(4);
    endtask

    task automatic test_zero_period();
        das_cycles = 0; arr_cycles = 0;
        action_user[3] = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            checks++;
            if (action_out[3] !== (c >= 3 && c <= 8) ||
                held[3] !== (c >= 3 && c <= 8)) begin
                errors++;
                $display("FAIL zero_period c=%0d out=%b held=%b expected %b",
                         c, action_out[3], held[3], (c >= 3 && c <= 8));
            end
            if (c == 6) action_user[3] = 1'b0;
        end
        idle(4);
    endtask

    task automatic test_reset_mid_arr();
        das_cycles = 10; arr_cycles = 4;
        action_user[0] = 1'b1;
        repeat (13) tick();
        checks++;
        if (action_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset out=%b expected 1", action_out[0]);
        end
        #2;
        rst_l = 1'b0;
        #1;
        checks++;
        if (action_out !== 4'b0 || held !== 4'b0) begin
            errors++;
            $display("FAIL async_reset out=%b held=%b expected 0000/0000",
                     action_out, held);
        end
        tick();
        rst_l = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if (action_out[0] !== (c == 3 || c == 13) || held[0] !== (c >= 3)) begin
                errors++;
                $display("FAIL post_reset c=%0d out=%b held=%b expected %b/%b",
                         c, action_out[0], held[0], (c == 3 || c == 13), (c >= 3));
            end
        end
        idle(4);
    endtask

    initial begin
        rst_l        = 1'b0;
        action_user  = '0;
        action_valid = 4'hF;
        repeat_en    = 4'hF;
        das_cycles   = 10;
        arr_cycles   = 4;
        test_reset();
        test_tap();
        test_hold(1'b1);
        test_hold(1'b0);
        test_valid_gating();
        test_multi_channel();
        test_zero_period();
        test_reset_mid_arr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
